// File: rtl/shift_load_ctrl_pkg.sv
// Shared types and defaults for the shift-register load sequencer.
// State codes are fixed so that read-back and debug tools see stable encodings.
package shift_load_ctrl_pkg;

    localparam int unsigned DefWidth = 6;
    localparam int unsigned DefCntW  = 3;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StShift = 3'd2,
        StCheck = 3'd3,
        StDone  = 3'd4
    } state_e;

endpackage

// File: rtl/shift_load_ctrl_if.sv
// Bus between the control/test logic, the sequencer and the shift chain.
// master is the sequencer's view; slave is the environment's view.
interface shift_load_ctrl_if #(
    parameter int unsigned WIDTH = 6
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] sr_q;
    logic             sh_en;
    logic             sh_in;
    logic             sr_clr;
    logic             busy;
    logic             done;
    logic             match;

    modport master (
        input  start, abort, pattern, sr_q,
        output sh_en, sh_in, sr_clr, busy, done, match
    );

    modport slave (
        output start, abort, pattern, sr_q,
        input  sh_en, sh_in, sr_clr, busy, done, match
    );
endinterface

// File: rtl/shift_bit_cnt.sv
// Bit counter for the serial shift phase: sync zero, increment, terminal flag at WIDTH-1.
module shift_bit_cnt #(
    parameter int unsigned CNT_W = 3,
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             i_zero,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_term
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt;
        if (i_zero) begin
            w_cnt_d = '0;
        end else if (i_inc) begin
            w_cnt_d = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_term = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_load_ctrl.sv
// Sequencer: clears the shift chain, shifts a latched pattern in MSB first,
// then compares the read-back against the pattern and pulses done.
module shift_load_ctrl
    import shift_load_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CNT_W = DefCntW
) (
    input logic               clk,
    input logic               clr,
    shift_load_ctrl_if.master bus
);

    state_e           r_state;
    state_e           w_state_d;
    logic [WIDTH-1:0] r_pat;
    logic [WIDTH-1:0] w_pat_d;
    logic             r_match;
    logic             w_match_d;
    logic             w_cnt_zero;
    logic             w_cnt_inc;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_term;
    logic [CNT_W-1:0] w_bit_idx;

    shift_bit_cnt #(
        .CNT_W (CNT_W),
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk    (clk),
        .clr    (clr),
        .i_zero (w_cnt_zero),
        .i_inc  (w_cnt_inc),
        .o_cnt  (w_cnt),
        .o_term (w_cnt_term)
    );

    always_comb begin
        w_state_d  = r_state;
        w_pat_d    = r_pat;
        w_match_d  = r_match;
        w_cnt_zero = 1'b0;
        w_cnt_inc  = 1'b0;
        case (r_state)
            StIdle: begin
                // abort is deliberately not looked at here, so start always wins
                if (bus.start) begin
                    w_pat_d   = bus.pattern;
                    w_match_d = 1'b0;
                    w_state_d = StClear;
                end
            end
            StClear: begin
                w_cnt_zero = 1'b1;
                if (bus.abort) begin
                    w_match_d = 1'b0;
                    w_state_d = StIdle;
                end else begin
                    w_state_d = StShift;
                end
            end
            StShift: begin
                if (bus.abort) begin
                    w_cnt_zero = 1'b1;
                    w_match_d  = 1'b0;
                    w_state_d  = StIdle;
                end else if (w_cnt_term) begin
                    w_cnt_zero = 1'b1;
                    w_state_d  = StCheck;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            StCheck: begin
                if (bus.abort) begin
                    w_cnt_zero = 1'b1;
                    w_match_d  = 1'b0;
                    w_state_d  = StIdle;
                end else begin
                    w_match_d = (bus.sr_q == r_pat);
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= StIdle;
            r_pat   <= '0;
            r_match <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_pat   <= w_pat_d;
            r_match <= w_match_d;
        end
    end

    // MSB first: bit index counts down from WIDTH-1 as the counter counts up
    assign w_bit_idx = CNT_W'(WIDTH - 1) - w_cnt;

    always_comb begin
        bus.sh_en  = (r_state == StShift);
        bus.sh_in  = (r_state == StShift) & r_pat[w_bit_idx];
        bus.sr_clr = (r_state == StClear);
        bus.busy   = (r_state != StIdle);
        bus.done   = (r_state == StDone);
        bus.match  = r_match;
    end

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Directed bench for shift_load_ctrl paired with a behavioural 6-stage shift chain
// that can have its leftmost stage stuck at 0.
module tb_shift_load_ctrl;

    localparam int unsigned W = 6;

    logic         clk;
    logic         clr;
    logic         fault_a;
    logic [W-1:0] r_sr;
    int           n_checks;
    int           n_fail;

    shift_load_ctrl_if #(.WIDTH(W)) bus ();

    shift_load_ctrl #(
        .WIDTH (W),
        .CNT_W (3)
    ) u_dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shift chain: sync clear, one left shift per enabled edge, serial in at the right.
    always_ff @(posedge clk) begin
        if (bus.sr_clr) begin
            r_sr <= '0;
        end else if (bus.sh_en) begin
            r_sr <= {r_sr[W-2:0], bus.sh_in};
        end
    end

    assign bus.sr_q = fault_a ? {1'b0, r_sr[W-2:0]} : r_sr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation from the accepting edge through the return to IDLE.
    task automatic run_op(input logic [W-1:0] pat, input logic [W-1:0] exp_sr,
                          input logic exp_match, input logic keep_start,
                          input logic [W-1:0] next_pat, input logic abort_acc);
        bus.start   = 1'b1;
        bus.pattern = pat;
        bus.abort   = abort_acc;
        tick();
        bus.start   = keep_start;
        bus.pattern = next_pat;
        bus.abort   = 1'b0;
        check("clear_sr_clr", 32'(bus.sr_clr), 32'd1);
        check("clear_busy", 32'(bus.busy), 32'd1);
        check("clear_sh_en", 32'(bus.sh_en), 32'd0);
        check("clear_match", 32'(bus.match), 32'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            check("shift_sh_en", 32'(bus.sh_en), 32'd1);
            check("shift_sh_in", 32'(bus.sh_in), 32'(pat[3'(5 - i)]));
            check("shift_sr_clr", 32'(bus.sr_clr), 32'd0);
            tick();
        end
        check("check_sh_en", 32'(bus.sh_en), 32'd0);
        check("check_sr_q", 32'(bus.sr_q), 32'(exp_sr));
        check("check_done", 32'(bus.done), 32'd0);
        tick();
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd1);
        check("done_match", 32'(bus.match), 32'(exp_match));
        tick();
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_sr_clr", 32'(bus.sr_clr), 32'd0);
        check("idle_match", 32'(bus.match), 32'(exp_match));
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        fault_a     = 1'b0;
        clr         = 1'b0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.pattern = '0;

        // 1: outputs stay low in reset even with start pulsing
        for (int i = 0; i < 3; i++) begin
            bus.start = (i != 1);
            tick();
            check("rst_busy", 32'(bus.busy), 32'd0);
            check("rst_done", 32'(bus.done), 32'd0);
            check("rst_match", 32'(bus.match), 32'd0);
            check("rst_sh_en", 32'(bus.sh_en), 32'd0);
            check("rst_sr_clr", 32'(bus.sr_clr), 32'd0);
        end
        bus.start = 1'b0;
        clr = 1'b1;
        tick();
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        // 2: basic load of 101101
        run_op(6'b101101, 6'b101101, 1'b1, 1'b0, 6'b000000, 1'b0);

        // 3: leftmost stage stuck at 0
        fault_a = 1'b1;
        run_op(6'b111111, 6'b011111, 1'b0, 1'b0, 6'b000000, 1'b0);
        fault_a = 1'b0;

        // 4: start held; pattern changes after accept; start in DONE ignored
        run_op(6'b000001, 6'b000001, 1'b1, 1'b1, 6'b110000, 1'b0);
        run_op(6'b110000, 6'b110000, 1'b1, 1'b0, 6'b000000, 1'b0);

        // 5: abort mid-SHIFT at cnt=3
        bus.start   = 1'b1;
        bus.pattern = 6'b111000;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("pre_abort_sh_en", 32'(bus.sh_en), 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_sh_en", 32'(bus.sh_en), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_match", 32'(bus.match), 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("abort_no_done", 32'(bus.done), 32'd0);
            tick();
        end
        // start and abort together in IDLE: start wins
        run_op(6'b010101, 6'b010101, 1'b1, 1'b0, 6'b000000, 1'b1);

        // 6: async reset asserted between edges mid-SHIFT
        bus.start   = 1'b1;
        bus.pattern = 6'b011011;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("pre_clr_sh_en", 32'(bus.sh_en), 32'd1);
        #2;
        clr = 1'b0;
        #1;
        check("mid_clr_sh_en", 32'(bus.sh_en), 32'd0);
        check("mid_clr_busy", 32'(bus.busy), 32'd0);
        check("mid_clr_sh_in", 32'(bus.sh_in), 32'd0);
        check("mid_clr_match", 32'(bus.match), 32'd0);
        #1;
        clr = 1'b1;
        tick();
        check("post_clr_busy", 32'(bus.busy), 32'd0);
        run_op(6'b100000, 6'b100000, 1'b1, 1'b0, 6'b000000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
